// File: rtl/code_decoder_if.sv
// Handshake bundle between the code encoder stage and the decoder stage.
// slave = decoder side, master = upstream/downstream driver side.
interface code_decoder_if;
  logic [6:0] code_in;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] value_out;
  logic       code_err;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  code_in, in_valid, out_ready,
    output in_ready, value_out, code_err, out_valid
  );

  modport master (
    output code_in, in_valid, out_ready,
    input  in_ready, value_out, code_err, out_valid
  );
endinterface

// File: rtl/code_decoder_stage.sv
// Decodes one-hot or Gray code words into a 3-bit value, one-cycle latency,
// counts invalid words and locks after three consecutive invalid words.
module code_decoder_stage #(
  parameter bit USE_GRAY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  code_decoder_if.slave         io,
  input  logic                  clear,
  output logic [7:0]            err_cnt,
  output logic                  locked
);

  typedef enum logic {RUN, LOCKED} state_e;

  state_e     state_q, state_d;
  logic       ov_q, ov_d;
  logic [2:0] val_q, val_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] con_q, con_d;

  logic [2:0] dec_val;
  logic       dec_err;
  logic       accept;

  always_comb begin
    dec_val = 3'd0;
    dec_err = 1'b0;
    if (USE_GRAY) begin
      if (|io.code_in[6:3]) begin
        dec_err = 1'b1;
      end else begin
        dec_val[2] = io.code_in[2];
        dec_val[1] = io.code_in[2] ^ io.code_in[1];
        dec_val[0] = io.code_in[2] ^ io.code_in[1]
                   ^ io.code_in[0];
      end
    end else begin
      case (io.code_in)
        7'h00:   dec_val = 3'd0;
        7'h01:   dec_val = 3'd1;
        7'h02:   dec_val = 3'd2;
        7'h04:   dec_val = 3'd3;
        7'h08:   dec_val = 3'd4;
        7'h10:   dec_val = 3'd5;
        7'h20:   dec_val = 3'd6;
        7'h40:   dec_val = 3'd7;
        default: dec_err = 1'b1;
      endcase
    end
  end

  // Ready is held low during reset so nothing is taken in that cycle.
  assign io.in_ready = !rst && (state_q == RUN)
                     && (!ov_q || io.out_ready);
  assign accept = io.in_valid && io.in_ready;

  always_comb begin
    state_d = state_q;
    ov_d    = ov_q;
    val_d   = val_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    con_d   = con_q;

    if (accept) begin
      ov_d  = 1'b1;
      val_d = dec_val;
      err_d = dec_err;
    end else if (io.out_ready) begin
      ov_d = 1'b0;
    end

    if (clear) begin
      cnt_d   = 8'd0;
      con_d   = 2'd0;
      state_d = RUN;
    end else if (accept) begin
      if (dec_err) begin
        if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        con_d = con_q + 2'd1;
        if (con_q == 2'd2) state_d = LOCKED;
      end else begin
        con_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ov_q    <= 1'b0;
      val_q   <= 3'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      con_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      val_q   <= val_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      con_q   <= con_d;
    end
  end

  assign io.out_valid = ov_q;
  assign io.value_out = val_q;
  assign io.code_err  = err_q;
  assign err_cnt      = cnt_q;
  assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_code_decoder_stage.sv
// Bench for code_decoder_stage: one-hot and Gray instances share stimulus,
// a reference model fills per-instance queues, a monitor drains them.
module tb_code_decoder_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [6:0] code = 7'd0;

  code_decoder_if ifc0();
  code_decoder_if ifc1();

  assign ifc0.code_in   = code;
  assign ifc0.in_valid  = in_valid;
  assign ifc0.out_ready = out_ready;
  assign ifc1.code_in   = code;
  assign ifc1.in_valid  = in_valid;
  assign ifc1.out_ready = out_ready;

  logic [7:0] cnt0, cnt1;
  logic       lk0, lk1;

  code_decoder_stage #(.USE_GRAY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .io(ifc0), .clear(clear),
    .err_cnt(cnt0), .locked(lk0)
  );

  code_decoder_stage #(.USE_GRAY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .io(ifc1), .clear(clear),
    .err_cnt(cnt1), .locked(lk1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference decode: {err, value}
  function automatic logic [3:0] ref_dec(int g, logic [6:0] c);
    int n, pos, b;
    n = 0;
    pos = 0;
    if (g == 0) begin
      for (int i = 0; i < 7; i++)
        if (c[i]) begin n++; pos = i + 1; end
      if (n == 0) return 4'b0000;
      if (n == 1) return {1'b0, pos[2:0]};
      return 4'b1000;
    end
    if (c[6:3] != 4'd0) return 4'b1000;
    b = int'(c[2:0]);
    b = b ^ (b >> 1) ^ (b >> 2);
    return {1'b0, b[2:0]};
  endfunction

  function automatic logic [6:0] enc_oh(int v);
    if (v == 0) return 7'd0;
    return 7'(1 << (v - 1));
  endfunction

  function automatic logic [6:0] enc_gray(int v);
    return 7'(v ^ (v >> 1));
  endfunction

  bit m_init = 1'b0;
  bit m_lock [2];
  bit m_ov [2];
  int m_cnt [2];
  int m_con [2];
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];

  task automatic model_step(int g);
    bit acc;
    logic [3:0] d;
    acc = in_valid && !rst && !m_lock[g] && (!m_ov[g] || out_ready);
    d = ref_dec(g, code);
    if (rst) begin
      m_lock[g] = 0; m_ov[g] = 0; m_cnt[g] = 0; m_con[g] = 0;
      if (g == 0) q0.delete(); else q1.delete();
      return;
    end
    if (acc) begin
      m_ov[g] = 1;
      if (g == 0) q0.push_back(d); else q1.push_back(d);
    end else if (out_ready) begin
      m_ov[g] = 0;
    end
    if (clear) begin
      m_cnt[g] = 0; m_con[g] = 0; m_lock[g] = 0;
    end else if (acc) begin
      if (d[3]) begin
        if (m_cnt[g] < 255) m_cnt[g]++;
        m_con[g]++;
        if (m_con[g] == 3) m_lock[g] = 1;
      end else begin
        m_con[g] = 0;
      end
    end
  endtask

  task automatic check_state(int g);
    bit er;
    er = !rst && !m_lock[g] && (!m_ov[g] || out_ready);
    if (g == 0) begin
      chk("in_ready0", 32'(ifc0.in_ready), 32'(er));
      chk("locked0", 32'(lk0), 32'(m_lock[0]));
      chk("err_cnt0", 32'(cnt0), 32'(m_cnt[0]));
      chk("out_valid0", 32'(ifc0.out_valid), 32'(m_ov[0]));
    end else begin
      chk("in_ready1", 32'(ifc1.in_ready), 32'(er));
      chk("locked1", 32'(lk1), 32'(m_lock[1]));
      chk("err_cnt1", 32'(cnt1), 32'(m_cnt[1]));
      chk("out_valid1", 32'(ifc1.out_valid), 32'(m_ov[1]));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (m_init) begin
      check_state(0);
      check_state(1);
    end
    model_step(0);
    model_step(1);
    if (rst) m_init = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [6:0] c, bit r, bit clr);
    in_valid  = v;
    code      = c;
    out_ready = r;
    clear     = clr;
    cycle();
  endtask

  // Monitor: pops expected words whenever a DUT output is consumed
  bit hold [2];
  logic [3:0] held [2];

  task automatic mon(int g);
    logic ov;
    logic [3:0] act, exp;
    ov  = (g == 0) ? ifc0.out_valid : ifc1.out_valid;
    act = (g == 0) ? {ifc0.code_err, ifc0.value_out}
                   : {ifc1.code_err, ifc1.value_out};
    if (hold[g]) begin
      chk($sformatf("hold_valid%0d", g), 32'(ov), 32'd1);
      chk($sformatf("hold_data%0d", g), 32'(act), 32'(held[g]));
    end
    hold[g] = (ov === 1'b1) && !out_ready && !rst;
    held[g] = act;
    if ((ov === 1'b1) && out_ready && !rst) begin
      if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out%0d: got %0d required none", g, act);
      end else begin
        exp = (g == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("data%0d", g), 32'(act), 32'(exp));
      end
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) mon(g);
  end

  initial begin
    int v, r;
    logic [6:0] c;

    drive(0, 7'd0, 0, 0);
    drive(0, 7'd0, 0, 0);
    rst = 1'b0;
    chk("rst_value0", 32'(ifc0.value_out), 32'd0);
    chk("rst_err0", 32'(ifc0.code_err), 32'd0);
    chk("rst_valid1", 32'(ifc1.out_valid), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);

    for (int k = 0; k < 8; k++) drive(1, enc_oh(k), 1, 0);
    drive(0, 7'd0, 1, 1);
    chk("oh_stream_cnt0", 32'(cnt0), 32'd0);

    drive(1, 7'b0000110, 1, 0);
    drive(1, 7'b0001010, 1, 0);
    drive(0, 7'd0, 1, 0);
    chk("gray_cnt1", 32'(cnt1), 32'd1);
    drive(0, 7'd0, 1, 1);

    for (int k = 0; k < 3; k++) drive(1, 7'(k + 1), 0, 0);
    for (int k = 0; k < 6; k++) drive(1, enc_oh(k), 1, 0);
    drive(0, 7'd0, 1, 1);

    for (int k = 0; k < 3; k++) drive(1, 7'b0000011, 1, 0);
    chk("lock0", 32'(lk0), 32'd1);
    chk("lock_cnt0", 32'(cnt0), 32'd3);
    drive(1, 7'b0000011, 1, 0);
    drive(0, 7'd0, 1, 1);
    chk("unlock0", 32'(lk0), 32'd0);
    chk("unlock_cnt0", 32'(cnt0), 32'd0);

    for (int k = 0; k < 256; k++) begin
      drive(1, 7'b0011000, 1, 0);
      drive(1, 7'b0000000, 1, 0);
    end
    chk("sat_cnt0", 32'(cnt0), 32'd255);
    chk("sat_cnt1", 32'(cnt1), 32'd255);
    drive(0, 7'd0, 1, 1);

    for (int k = 0; k < 400; k++) begin
      v = int'($urandom_range(0, 7));
      r = int'($urandom_range(0, 9));
      if (r < 4) c = enc_oh(v);
      else if (r < 8) c = enc_gray(v);
      else c = 7'($urandom);
      drive(1'($urandom_range(0, 3) != 0), c,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
    end

    drive(0, 7'd0, 1, 1);
    drive(1, 7'd0, 0, 0);
    drive(1, 7'd1, 0, 0);
    rst = 1'b1;
    drive(1, 7'd2, 0, 1);
    rst = 1'b0;
    chk("rst_mid_valid0", 32'(ifc0.out_valid), 32'd0);
    chk("rst_mid_cnt0", 32'(cnt0), 32'd0);
    chk("rst_mid_lock1", 32'(lk1), 32'd0);

    drive(0, 7'd0, 1, 0);
    drive(0, 7'd0, 1, 0);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/code_decoder_stage.md
CODE_DECODER_STAGE -- requirements
Module: code_decoder_stage

Interface
REQ-001 The block SHALL have parameter USE_GRAY, default 0, selecting the code format: 0 = one-hot, 1 = Gray.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port code_in, input, 7 bits: the code word from the upstream encoder stage.
REQ-005 The block SHALL have port in_valid, input, 1 bit: code_in is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the stage accepts code_in this cycle.
REQ-007 The block SHALL have port value_out, output, 3 bits: the decoded value.
REQ-008 The block SHALL have port code_err, output, 1 bit: the word in the output register was an invalid code.
REQ-009 The block SHALL have port out_valid, output, 1 bit: value_out and code_err are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the output this cycle.
REQ-011 The block SHALL have port clear, input, 1 bit: single-cycle pulse that clears the error state.
REQ-012 The block SHALL have port err_cnt, output, 8 bits: saturating count of accepted invalid codes.
REQ-013 The block SHALL have port locked, output, 1 bit: high while the stage is in the LOCKED state.

Function
REQ-014 Code map for USE_GRAY=0: value 0 -> 7'b0000000; value k (1..7) -> only bit k-1 set; any word with two or more bits set SHALL be invalid.
REQ-015 Code map for USE_GRAY=1: code_in[2:0] = Gray(value) and code_in[6:3] = 0; any nonzero code_in[6:3] SHALL be invalid.
REQ-016 An invalid word SHALL decode to value_out=3'b000 with code_err=1; a valid word SHALL decode with code_err=0.
REQ-017 A word SHALL be accepted when in_valid && in_ready.
REQ-018 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready); it is combinational and takes no extra bubble cycle.
REQ-019 Latency SHALL be 1 cycle: an accepted word appears on value_out/code_err with out_valid=1 on the next cycle.
REQ-020 While out_valid && !out_ready, value_out, code_err and out_valid SHALL hold stable.
REQ-021 out_valid SHALL clear after a cycle with out_ready=1 in which no new word is accepted.
REQ-022 A word SHALL be accepted in the same cycle the output is consumed, giving full throughput of 1 word/cycle.
REQ-023 err_cnt SHALL increment by 1 on each accepted invalid word and saturate at 255.
REQ-024 A 2-bit consecutive-invalid counter SHALL increment on each accepted invalid word and reset to 0 on each accepted valid word.
REQ-025 The state machine SHALL have two states: RUN and LOCKED; locked = (state==LOCKED).
REQ-026 RUN->LOCKED SHALL occur on acceptance of the 3rd consecutive invalid word; that word is still forwarded with code_err=1.
REQ-027 In LOCKED, in_ready SHALL be 0, and a pending output SHALL still drain normally.
REQ-028 clear SHALL, in either state, set err_cnt=0 and the consecutive counter to 0, and set state to RUN on the next cycle.
REQ-029 clear coincident with an accepted word SHALL win over counting: counters become 0 and no lock occurs, while the word is still forwarded with its code_err.

Reset
REQ-030 rst SHALL force state=RUN, out_valid=0, value_out=0, code_err=0, err_cnt=0, the consecutive counter to 0 and locked=0 on the next edge.
REQ-031 rst SHALL override clear and any handshake, including mid-transfer: the pending output is discarded.
REQ-032 in_ready SHALL be 0 during the reset cycle.

Verification
REQ-033 With USE_GRAY=0 and out_ready=1, stream values 0..7 as their one-hot codes -> value_out = 0..7 one cycle later, code_err=0, err_cnt=0.
REQ-034 With USE_GRAY=1, send 7'b0000110 then 7'b0001010 -> first word gives value_out=4, code_err=0; second word gives value_out=0, code_err=1, err_cnt=1.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> one word is accepted, in_ready=0, and the output stays stable; out_ready=1 then resumes 1 word/cycle with no loss or duplication.
REQ-036 With USE_GRAY=0, send 3 invalid words (7'b0000011) -> locked=1 after the third, in_ready=0, err_cnt=3; pulse clear -> locked=0, err_cnt=0.
REQ-037 Send 256 invalid words with a valid word between each pair -> err_cnt=255 and locked never asserted.
REQ-038 Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, err_cnt=0, locked=0.
